video_timing: RTL

Raster timing generator clocked by the switchable video clock from the clock-control block. It produces horizontal/vertical counters, sync, blanking and line/frame strobes for the video pipeline. Two modes are supported: 704-pixel mode on the 28.63636 MHz clock and 640-pixel mode on the 25.175 MHz clock. Both give a 31.47 kHz line rate and 525 lines. Mode changes are applied only at a frame boundary, so the glitch-free clock switch never produces a truncated line.

---
 rtl/video_timing.sv | 103 ++++++++++
 1 files changed

// File: rtl/video_timing.sv
// video_timing: 525-line raster generator, 704 px (mode 0) or 640 px (mode 1).
// The mode request is synchronised and then latched only at the frame wrap, so
// every frame is generated in one mode from start to end. The sync, blank and
// strobe outputs are decoded from the next-state counters so they line up with
// the registered hpos/vpos.
module video_timing (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_mode,
  output logic       mode_active,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank,
  output logic       newline,
  output logic       newframe
);

  localparam logic [9:0] VACTIVE  = 10'd480;
  localparam logic [9:0] VS_START = 10'd490;
  localparam logic [9:0] VS_END   = 10'd491;
  localparam logic [9:0] VLAST    = 10'd524;

  logic       sync1_q, sync2_q;
  logic       mode_q, mode_d;
  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_n_q, vsync_n_q, blank_q, newline_q, newframe_q;
  logic       hsync_n_d, vsync_n_d, blank_d, newline_d, newframe_d;

  logic [9:0] hlast_cur;
  logic [9:0] hlast_nxt, hact_nxt, hs_start_nxt, hs_end_nxt;
  logic       hwrap, fwrap;

  // Two-flop synchroniser for the asynchronous mode request.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= video_mode;
      sync2_q <= sync1_q;
    end
  end

  // Counter advance and mode adoption at the frame wrap.
  always_comb begin
    hlast_cur = mode_q ? 10'd799 : 10'd909;
    hwrap     = (hpos_q == hlast_cur);
    fwrap     = hwrap && (vpos_q == VLAST);
    hpos_d    = hwrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d    = vpos_q;
    if (hwrap) vpos_d = (vpos_q == VLAST) ? 10'd0 : vpos_q + 10'd1;
    mode_d    = fwrap ? sync2_q : mode_q;
  end

  // Output decode from the next-state counters, using the mode they will run in.
  always_comb begin
    hlast_nxt    = mode_d ? 10'd799 : 10'd909;
    hact_nxt     = mode_d ? 10'd640 : 10'd704;
    hs_start_nxt = mode_d ? 10'd656 : 10'd756;
    hs_end_nxt   = mode_d ? 10'd751 : 10'd863;
    hsync_n_d    = !((hpos_d >= hs_start_nxt) && (hpos_d <= hs_end_nxt));
    vsync_n_d    = !((vpos_d >= VS_START) && (vpos_d <= VS_END));
    blank_d      = (hpos_d >= hact_nxt) || (vpos_d >= VACTIVE);
    newline_d    = (hpos_d == hlast_nxt);
    newframe_d   = newline_d && (vpos_d == VLAST);
  end

  // Counter, mode and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q     <= 10'd0;
      vpos_q     <= 10'd0;
      mode_q     <= 1'b0;
      hsync_n_q  <= 1'b1;
      vsync_n_q  <= 1'b1;
      blank_q    <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
    end else begin
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      mode_q     <= mode_d;
      hsync_n_q  <= hsync_n_d;
      vsync_n_q  <= vsync_n_d;
      blank_q    <= blank_d;
      newline_q  <= newline_d;
      newframe_q <= newframe_d;
    end
  end

  assign mode_active = mode_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign blank       = blank_q;
  assign newline     = newline_q;
  assign newframe    = newframe_q;

endmodule
